sb_spi: RTL and testbench
=========================

// Module: sb_spi
// PURPOSE
// - Behavioural model of the iCE40UP hard SPI block, slave mode only. Sits between the fabric
//   control FSM (8-bit strobe/ack register bus) and the external SPI pins.
// - Fabric configures it through CR0..CR2/BR/CSR and moves bytes through TXDR/RXDR, polling SR.
// PARAMETERS
// - BUS_ADDR74  4'b0000  block responds only when SBADRI[7:4] == BUS_ADDR74.
// PORTS
// - SBCLKI   in   1  system clock; all logic on its rising edge.
// - SBRSTNI  in   1  reset, asynchronous, active-low.
// - SBSTBI   in   1  bus strobe.  SBRWI  in 1  1=write, 0=read.
// - SBADRI   in   8  register address.  SBDATI  in 8  write data.
// - SBDATO   out  8  read data.  SBACKO  out 1  transfer-done pulse.
// - SCKI, SCSNI, SI  in 1 each  SPI clock, chip select (active-low) and MOSI from the host.
// - SO   out 1  MISO data.  SOE  out 1  MISO output enable.
// - MI   in  1  unused.  MO  out 1  tied 0.
// BEHAVIOUR
// - Reset: all registers 0, SR.TRDY=1, SBACKO=0, SBDATO=0, SO=0, SOE=0. Reset mid-byte discards
//   the partial byte and the bit count.
// - Bus: SBSTBI sampled high while SBACKO=0 and address in block -> SBACKO=1 for exactly one cycle
//   on the next edge. SBDATO holds read data in that cycle, 0 otherwise. SBSTBI is ignored
//   during the ack cycle. Out-of-block or unmapped addresses (low nibble < 8) never ack.
// - Map (low nibble): 8 CR0, 9 CR1, A CR2, B BR, F CSR are R/W storage. C SR is read-only.
//   D TXDR is write-only; a read returns 0. E RXDR is read-only.
// - Active config bits: CR1[7] enable; CR2[0] LSB-first; CR2[2:1] CPOL/CPHA. Other bits are
//   stored only.
// - SR bit map: [7] TIP, byte in progress; [4] TRDY, TX holding empty; [3] RRDY, RX byte
//   waiting; [2] TOE, TX underrun; [1] ROE, RX overrun. Others 0. Reading SR clears TOE and ROE.
// - TXDR write: hold <= data, TRDY <= 0.  RXDR read: returns rx byte, RRDY <= 0.
// - Pins: SCKI, SCSNI and SI pass through 2-FF synchronizers; edges are detected in the SBCLKI
//   domain. Required: SCK period >= 4 SBCLKI periods.
// - While disabled (CR1[7]=0) or SCSNI=1: bit count = 0, TIP=0, SOE=0, SO=0.
// - Frame start (SCSNI falls while enabled):
//   - load shift register from hold if TRDY=0, then TRDY <= 1;
//   - otherwise load 8'h00 and set TOE.
// - Shifting: sample SI on the sampling edge (mode 0 rising), present next bit on the opposite
//   edge. The first bit is driven immediately on load. Bit order: LSB first if CR2[0], else MSB.
// - After the 8th sample:
//   - rx byte -> RXDR; if RRDY was already 1, set ROE and overwrite; RRDY <= 1;
//   - reload the shift register from hold as at frame start; bit count wraps to 0.
// - Simultaneous events: a TXDR write in the same cycle as a reload is not taken (TRDY stays 0
//   and the byte goes out next). An RXDR read in the same cycle as a byte completion returns the
//   old byte and leaves RRDY=1.
// - SOE = enabled & ~SCSNI (synchronized).
// STRUCTURE
// - Shared package: register address constants (CR0..CSR), SR bit indices, CR bit indices.
// - One sub-module: sb_spi_sync, a 2-FF synchronizer with edge detect, used for SCKI, SCSNI
//   and SI.
// TESTING
// - Write CR1=8'h80 -> SBACKO high exactly 1 cycle after the strobe; read CR1 back = 8'h80;
//   addr 8'h1A -> no ack.
// - CR2=1, host sends 8'h11 LSB-first -> SR[3]=1; RXDR read = 8'h11; next SR read has [3]=0.
// - TXDR=8'h40 before SCSNI falls -> SR[4]=0, then 1 after load; host samples 8'h40 on SO.
// - Two bytes sent without an RXDR read -> SR[1]=1, RXDR = second byte; SR re-read -> [1]=0.
// - CR1=0 while host clocks 8 bits -> SR[3]=0, SO=0, SOE=0.
// - SBRSTNI pulsed low after 4 bits -> SR reads 8'h10; a fresh 8-bit frame is received intact.

Source files
------------

// File: rtl/sb_spi_pkg.sv
// Shared constants for the sb_spi slave SPI block: register offsets, status and control bit positions.
package sb_spi_pkg;

  localparam logic [3:0] ADDR_CR0  = 4'h8;
  localparam logic [3:0] ADDR_CR1  = 4'h9;
  localparam logic [3:0] ADDR_CR2  = 4'hA;
  localparam logic [3:0] ADDR_BR   = 4'hB;
  localparam logic [3:0] ADDR_SR   = 4'hC;
  localparam logic [3:0] ADDR_TXDR = 4'hD;
  localparam logic [3:0] ADDR_RXDR = 4'hE;
  localparam logic [3:0] ADDR_CSR  = 4'hF;

  localparam logic [2:0] SR_TIP  = 3'd7;
  localparam logic [2:0] SR_TRDY = 3'd4;
  localparam logic [2:0] SR_RRDY = 3'd3;
  localparam logic [2:0] SR_TOE  = 3'd2;
  localparam logic [2:0] SR_ROE  = 3'd1;

  localparam logic [2:0] CR1_EN   = 3'd7;
  localparam logic [2:0] CR2_LSBF = 3'd0;
  localparam logic [2:0] CR2_CPHA = 3'd1;
  localparam logic [2:0] CR2_CPOL = 3'd2;

  // Data is sampled on the rising SCK edge when CPOL and CPHA agree, else on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/sb_spi_sync.sv
// Two-flop synchronizer for one SPI pin, with rise/fall detection in the system clock domain.
module sb_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_r;

  // Shift the pin through two metastability stages plus one history stage for edge detection.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {3{RST_VAL}};
    end else begin
      sync_r <= {sync_r[1:0], d};
    end
  end

  assign q    = sync_r[1];
  assign rise = sync_r[1] & ~sync_r[2];
  assign fall = ~sync_r[1] & sync_r[2];

endmodule

// File: rtl/sb_spi.sv
// Slave-only SPI block with an 8-bit strobe/ack register bus: config, status, TX holding and RX data.
module sb_spi
  import sb_spi_pkg::*;
#(
  parameter logic [3:0] BUS_ADDR74 = 4'b0000
) (
  input  logic       SBCLKI,
  input  logic       SBRSTNI,
  input  logic       SBSTBI,
  input  logic       SBRWI,
  input  logic [7:0] SBADRI,
  input  logic [7:0] SBDATI,
  output logic [7:0] SBDATO,
  output logic       SBACKO,
  input  logic       SCKI,
  input  logic       SCSNI,
  input  logic       SI,
  output logic       SO,
  output logic       SOE,
  input  logic       MI,
  output logic       MO
);

  logic [7:0] cr0_r, cr1_r, cr2_r, br_r, csr_r;
  logic [7:0] hold_r, tx_sr_r, rx_sr_r, rxdr_r, dato_r;
  logic       trdy_r, rrdy_r, toe_r, roe_r, shift_pend_r;
  logic       ack_r, so_r, soe_r;
  logic [2:0] bit_cnt_r;

  logic sck_lvl_s, sck_rise_s, sck_fall_s;
  logic csn_lvl_s, csn_rise_s, csn_fall_s;
  logic si_lvl_s, si_rise_s, si_fall_s;

  sb_spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .CLK(SBCLKI), .rst_n(SBRSTNI), .d(SCKI), .q(sck_lvl_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );
  // Chip select resets to its idle level so reset release does not fake a frame start.
  sb_spi_sync #(.RST_VAL(1'b1)) u_sync_csn (
    .CLK(SBCLKI), .rst_n(SBRSTNI), .d(SCSNI), .q(csn_lvl_s), .rise(csn_rise_s), .fall(csn_fall_s)
  );
  sb_spi_sync #(.RST_VAL(1'b0)) u_sync_si (
    .CLK(SBCLKI), .rst_n(SBRSTNI), .d(SI), .q(si_lvl_s), .rise(si_rise_s), .fall(si_fall_s)
  );

  logic unused_s;
  assign unused_s = ^{MI, sck_lvl_s, csn_rise_s, si_rise_s, si_fall_s};

  logic addr_hit_s, wr_s, rd_s, sr_rd_s, rxdr_rd_s, txdr_wr_s;
  logic enable_s, active_s, lsbf_s, samp_edge_s, shift_edge_s;
  logic frame_start_s, sample_s, byte_done_s, reload_s, shift_s, tip_s;
  logic [7:0] rx_next_s, sr_val_s, rd_data_s;

  assign addr_hit_s = SBSTBI & ~ack_r & (SBADRI[7:4] == BUS_ADDR74) & SBADRI[3];
  assign wr_s       = addr_hit_s & SBRWI;
  assign rd_s       = addr_hit_s & ~SBRWI;
  assign sr_rd_s    = rd_s & (SBADRI[3:0] == ADDR_SR);
  assign rxdr_rd_s  = rd_s & (SBADRI[3:0] == ADDR_RXDR);
  assign txdr_wr_s  = wr_s & (SBADRI[3:0] == ADDR_TXDR);

  assign enable_s      = cr1_r[CR1_EN];
  assign active_s      = enable_s & ~csn_lvl_s;
  assign lsbf_s        = cr2_r[CR2_LSBF];
  assign samp_edge_s   = sample_on_rise(cr2_r[CR2_CPOL], cr2_r[CR2_CPHA]) ? sck_rise_s : sck_fall_s;
  assign shift_edge_s  = sample_on_rise(cr2_r[CR2_CPOL], cr2_r[CR2_CPHA]) ? sck_fall_s : sck_rise_s;
  assign frame_start_s = enable_s & csn_fall_s;
  assign sample_s      = active_s & samp_edge_s & ~frame_start_s;
  assign byte_done_s   = sample_s & (bit_cnt_r == 3'd7);
  assign reload_s      = frame_start_s | byte_done_s;
  // Only shift after a bit was sampled in this byte, so CPHA=1 does not skip the preloaded first bit.
  assign shift_s       = active_s & shift_edge_s & shift_pend_r;
  assign rx_next_s     = lsbf_s ? {si_lvl_s, rx_sr_r[7:1]} : {rx_sr_r[6:0], si_lvl_s};
  assign tip_s         = active_s & (bit_cnt_r != 3'd0);
  assign sr_val_s      = {tip_s, 2'b00, trdy_r, rrdy_r, toe_r, roe_r, 1'b0};

  // Register read multiplexer; write-only and unmapped offsets read as zero.
  always_comb begin
    rd_data_s = 8'h00;
    case (SBADRI[3:0])
      ADDR_CR0:  rd_data_s = cr0_r;
      ADDR_CR1:  rd_data_s = cr1_r;
      ADDR_CR2:  rd_data_s = cr2_r;
      ADDR_BR:   rd_data_s = br_r;
      ADDR_SR:   rd_data_s = sr_val_s;
      ADDR_RXDR: rd_data_s = rxdr_r;
      ADDR_CSR:  rd_data_s = csr_r;
      default:   rd_data_s = 8'h00;
    endcase
  end

  // Bus handshake: one-cycle ack with read data presented only during the ack.
  always_ff @(posedge SBCLKI or negedge SBRSTNI) begin
    if (!SBRSTNI) begin
      ack_r  <= 1'b0;
      dato_r <= 8'h00;
    end else begin
      ack_r  <= addr_hit_s;
      dato_r <= rd_s ? rd_data_s : 8'h00;
    end
  end

  // Configuration storage registers.
  always_ff @(posedge SBCLKI or negedge SBRSTNI) begin
    if (!SBRSTNI) begin
      cr0_r <= 8'h00;
      cr1_r <= 8'h00;
      cr2_r <= 8'h00;
      br_r  <= 8'h00;
      csr_r <= 8'h00;
    end else if (wr_s) begin
      case (SBADRI[3:0])
        ADDR_CR0: cr0_r <= SBDATI;
        ADDR_CR1: cr1_r <= SBDATI;
        ADDR_CR2: cr2_r <= SBDATI;
        ADDR_BR:  br_r  <= SBDATI;
        ADDR_CSR: csr_r <= SBDATI;
        default:  cr0_r <= cr0_r;
      endcase
    end
  end

  // Transmit path; a TXDR write coinciding with a reload lands in hold after the reload.
  always_ff @(posedge SBCLKI or negedge SBRSTNI) begin
    if (!SBRSTNI) begin
      hold_r       <= 8'h00;
      tx_sr_r      <= 8'h00;
      trdy_r       <= 1'b1;
      toe_r        <= 1'b0;
      shift_pend_r <= 1'b0;
    end else begin
      if (sr_rd_s) toe_r <= 1'b0;
      if (reload_s) begin
        if (!trdy_r) begin
          tx_sr_r <= hold_r;
          trdy_r  <= 1'b1;
        end else begin
          tx_sr_r <= 8'h00;
          toe_r   <= 1'b1;
        end
      end else if (shift_s) begin
        tx_sr_r <= lsbf_s ? {1'b0, tx_sr_r[7:1]} : {tx_sr_r[6:0], 1'b0};
      end
      if (txdr_wr_s) begin
        hold_r <= SBDATI;
        trdy_r <= 1'b0;
      end
      if (!active_s || reload_s) shift_pend_r <= 1'b0;
      else if (sample_s)         shift_pend_r <= 1'b1;
      else if (shift_s)          shift_pend_r <= 1'b0;
    end
  end

  // Receive path; a byte completion wins over an RXDR read in the same cycle.
  always_ff @(posedge SBCLKI or negedge SBRSTNI) begin
    if (!SBRSTNI) begin
      bit_cnt_r <= 3'd0;
      rx_sr_r   <= 8'h00;
      rxdr_r    <= 8'h00;
      rrdy_r    <= 1'b0;
      roe_r     <= 1'b0;
    end else begin
      if (!active_s || frame_start_s) bit_cnt_r <= 3'd0;
      else if (sample_s)              bit_cnt_r <= bit_cnt_r + 3'd1;
      if (sample_s) rx_sr_r <= rx_next_s;
      if (sr_rd_s)   roe_r  <= 1'b0;
      if (rxdr_rd_s) rrdy_r <= 1'b0;
      if (byte_done_s) begin
        rxdr_r <= rx_next_s;
        rrdy_r <= 1'b1;
        if (rrdy_r) roe_r <= 1'b1;
      end
    end
  end

  // MISO pin drivers, quiet whenever the block is not selected and enabled.
  always_ff @(posedge SBCLKI or negedge SBRSTNI) begin
    if (!SBRSTNI) begin
      so_r  <= 1'b0;
      soe_r <= 1'b0;
    end else begin
      so_r  <= active_s & (lsbf_s ? tx_sr_r[0] : tx_sr_r[7]);
      soe_r <= active_s;
    end
  end

  assign SBACKO = ack_r;
  assign SBDATO = dato_r;
  assign SO     = so_r;
  assign SOE    = soe_r;
  assign MO     = 1'b0;

endmodule

// File: tb/tb_sb_spi.sv
// Randomized scoreboard bench for sb_spi: bus reads checked by a monitor, SPI host model checks MISO.
module tb_sb_spi;

  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0, rw = 1'b0;
  logic [7:0] adr = 8'h00, dati = 8'h00;
  logic [7:0] SBDATO;
  logic       SBACKO;
  logic       SCKI = 1'b0, SCSNI = 1'b1, SI = 1'b0, MI = 1'b0;
  logic       SO, SOE, MO;

  sb_spi #(.BUS_ADDR74(4'b0000)) dut (
    .SBCLKI(clk), .SBRSTNI(rst_n), .SBSTBI(stb), .SBRWI(rw), .SBADRI(adr), .SBDATI(dati),
    .SBDATO(SBDATO), .SBACKO(SBACKO), .SCKI(SCKI), .SCSNI(SCSNI), .SI(SI),
    .SO(SO), .SOE(SOE), .MI(MI), .MO(MO)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct { logic [7:0] adr; logic [7:0] exp; } bus_exp_t;
  bus_exp_t bus_q[$];

  // Reference model: register file, TX holding state, RX state, current outgoing byte.
  logic [7:0] m_reg [16];
  logic [7:0] m_hold, m_rxdr, m_tx;
  logic       m_hold_valid, m_rrdy, m_toe, m_roe;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    m_hold = 8'h00; m_rxdr = 8'h00; m_tx = 8'h00;
    m_hold_valid = 1'b0; m_rrdy = 1'b0; m_toe = 1'b0; m_roe = 1'b0;
  endtask

  task automatic model_load();
    if (m_hold_valid) begin
      m_tx = m_hold;
      m_hold_valid = 1'b0;
    end else begin
      m_tx = 8'h00;
      m_toe = 1'b1;
    end
  endtask

  task automatic model_rx(input logic [7:0] d);
    if (m_rrdy) m_roe = 1'b1;
    m_rxdr = d;
    m_rrdy = 1'b1;
  endtask

  // Monitor: every ack pops one expectation; outside acks the read bus must be zero.
  always @(negedge clk) begin
    if (SBACKO === 1'b1) begin
      if (bus_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with data %02h, required no ack", SBDATO);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        chk($sformatf("bus_data_%02h", e.adr), SBDATO, e.exp);
      end
    end else if (rst_n) begin
      chk("dato_idle", SBDATO, 8'h00);
    end
  end

  task automatic bus_op(input logic wr, input logic [7:0] a, input logic [7:0] d);
    bus_exp_t x;
    logic [7:0] e;
    e = 8'h00;
    if (wr) begin
      case (a[3:0])
        4'hD:       begin m_hold = d; m_hold_valid = 1'b1; end
        4'hC, 4'hE: e = 8'h00;
        default:    m_reg[a[3:0]] = d;
      endcase
    end else begin
      case (a[3:0])
        4'hC: begin
          e = {3'b000, ~m_hold_valid, m_rrdy, m_toe, m_roe, 1'b0};
          m_toe = 1'b0; m_roe = 1'b0;
        end
        4'hD: e = 8'h00;
        4'hE: begin e = m_rxdr; m_rrdy = 1'b0; end
        default: e = m_reg[a[3:0]];
      endcase
    end
    x.adr = a; x.exp = e;
    bus_q.push_back(x);
    @(negedge clk); stb = 1'b1; rw = wr; adr = a; dati = d;
    @(negedge clk); chk("ack_pulse", {7'd0, SBACKO}, 8'h01); stb = 1'b0;
    @(negedge clk); chk("ack_single", {7'd0, SBACKO}, 8'h00);
  endtask

  task automatic bus_noack(input logic [7:0] a);
    @(negedge clk); stb = 1'b1; rw = 1'($urandom); adr = a; dati = 8'($urandom);
    @(negedge clk); chk($sformatf("noack_%02h", a), {7'd0, SBACKO}, 8'h00); stb = 1'b0;
    @(negedge clk); chk($sformatf("noack_%02h", a), {7'd0, SBACKO}, 8'h00);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsbf, input logic [4:0] upper);
    bus_op(1'b1, 8'h0A, {upper, cpol, cpha, lsbf});
    SCKI = cpol;
    #100;
  endtask

  // Host clocks nbits bits; checks each MISO bit just before the host would sample it.
  task automatic host_bits(input logic [7:0] mosi, input int nbits, input logic [7:0] exp_miso,
                           input logic lsbf, input logic cpha, input logic en);
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = lsbf ? i : 7 - i;
      if (!cpha) begin
        SI = mosi[b];
        #HALF;
        chk($sformatf("so_bit%0d", i), {7'd0, SO}, {7'd0, en & exp_miso[b]});
        chk("soe", {7'd0, SOE}, {7'd0, en});
        SCKI = ~SCKI;
        #HALF;
        SCKI = ~SCKI;
      end else begin
        SCKI = ~SCKI;
        SI = mosi[b];
        #HALF;
        chk($sformatf("so_bit%0d", i), {7'd0, SO}, {7'd0, en & exp_miso[b]});
        chk("soe", {7'd0, SOE}, {7'd0, en});
        SCKI = ~SCKI;
        #HALF;
      end
    end
  endtask

  task automatic frame_core(input int n, input logic [7:0] d0, input logic use_d0);
    logic en, lsbf, cpha;
    logic [7:0] mosi;
    en = m_reg[9][7]; lsbf = m_reg[10][0]; cpha = m_reg[10][1];
    SCSNI = 1'b0;
    #100;
    if (en) model_load();
    for (int k = 0; k < n; k++) begin
      mosi = (k == 0 && use_d0) ? d0 : 8'($urandom);
      host_bits(mosi, 8, en ? m_tx : 8'h00, lsbf, cpha, en);
      if (en) begin
        model_rx(mosi);
        model_load();
      end
    end
    #100;
    SCSNI = 1'b1;
    #100;
  endtask

  initial begin
    logic [7:0] r;
    model_reset();
    #22;
    chk("rst_ack", {7'd0, SBACKO}, 8'h00);
    chk("rst_dato", SBDATO, 8'h00);
    chk("rst_so", {7'd0, SO}, 8'h00);
    chk("rst_soe", {7'd0, SOE}, 8'h00);
    rst_n = 1'b1;
    #30;
    bus_op(1'b0, 8'h0C, 8'h00);
    bus_op(1'b0, 8'h09, 8'h00);

    bus_op(1'b1, 8'h09, 8'h80);
    bus_op(1'b0, 8'h09, 8'h00);
    bus_noack(8'h1A);
    bus_noack(8'h05);

    set_mode(1'b0, 1'b0, 1'b1, 5'd0);
    frame_core(1, 8'h11, 1'b1);
    bus_op(1'b0, 8'h0C, 8'h00);
    bus_op(1'b0, 8'h0E, 8'h00);
    bus_op(1'b0, 8'h0C, 8'h00);

    set_mode(1'b0, 1'b0, 1'b0, 5'd0);
    bus_op(1'b1, 8'h0D, 8'h40);
    bus_op(1'b0, 8'h0C, 8'h00);
    frame_core(1, 8'h3C, 1'b1);
    bus_op(1'b0, 8'h0C, 8'h00);
    bus_op(1'b0, 8'h0D, 8'h00);

    frame_core(2, 8'h00, 1'b0);
    bus_op(1'b0, 8'h0C, 8'h00);
    bus_op(1'b0, 8'h0E, 8'h00);
    bus_op(1'b0, 8'h0C, 8'h00);

    bus_op(1'b1, 8'h09, 8'h00);
    frame_core(1, 8'h5A, 1'b1);
    bus_op(1'b0, 8'h0C, 8'h00);

    // Reset in the middle of a byte, then a clean frame.
    bus_op(1'b1, 8'h09, 8'h80);
    SCSNI = 1'b0;
    #100;
    model_load();
    host_bits(8'hC3, 4, m_tx, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #20;
    chk("midrst_so", {7'd0, SO}, 8'h00);
    chk("midrst_soe", {7'd0, SOE}, 8'h00);
    chk("midrst_ack", {7'd0, SBACKO}, 8'h00);
    rst_n = 1'b1;
    model_reset();
    SCSNI = 1'b1;
    SCKI = 1'b0;
    #100;
    bus_op(1'b0, 8'h0C, 8'h00);
    bus_op(1'b1, 8'h09, 8'h80);
    set_mode(1'b0, 1'b0, 1'b0, 5'd0);
    frame_core(1, 8'hA5, 1'b1);
    bus_op(1'b0, 8'h0E, 8'h00);
    bus_op(1'b0, 8'h0C, 8'h00);

    for (int it = 0; it < 20; it++) begin
      set_mode(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      bus_op(1'b1, 8'h09, {1'b1, 7'($urandom)});
      bus_op(1'b1, 8'h08, 8'($urandom));
      bus_op(1'b1, 8'h0B, 8'($urandom));
      bus_op(1'b1, 8'h0F, 8'($urandom));
      if ($urandom_range(0, 3) == 0) bus_op(1'b1, {4'h0, ($urandom_range(0, 1) == 0) ? 4'hC : 4'hE}, 8'($urandom));
      r = {4'h0, 4'h8 + 4'($urandom_range(0, 7))};
      bus_op(1'b0, r, 8'h00);
      if ($urandom_range(0, 1) == 1) bus_op(1'b1, 8'h0D, 8'($urandom));
      if ($urandom_range(0, 2) == 0) bus_noack({4'($urandom_range(1, 15)), 4'($urandom)});
      else bus_noack({4'h0, 1'b0, 3'($urandom)});
      frame_core($urandom_range(1, 3), 8'h00, 1'b0);
      if ($urandom_range(0, 1) == 1) bus_op(1'b0, 8'h0C, 8'h00);
      if ($urandom_range(0, 1) == 1) bus_op(1'b0, 8'h0E, 8'h00);
      bus_op(1'b0, 8'h0C, 8'h00);
      bus_op(1'b0, 8'h0A, 8'h00);
    end

    repeat (4) @(negedge clk);
    chk("bus_q_empty", 8'(bus_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
